// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: collects A, B, OPCODE frames from the UART receiver, waits for the ALU and hands the result to the transmitter
module uart_alu_sequencer #(
  parameter int LEN_DATA       = 8,
  parameter int LEN_OPCODE     = 6,
  parameter int ALU_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [LEN_DATA-1:0]   rx_data_in,
  input  logic                  tx_done_tick,
  input  logic [LEN_DATA-1:0]   alu_data_in,
  output logic [LEN_DATA-1:0]   A,
  output logic [LEN_DATA-1:0]   B,
  output logic [LEN_OPCODE-1:0] OPCODE,
  output logic [LEN_DATA-1:0]   data_out,
  output logic                  tx_start,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  overrun
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int LW = ALU_LATENCY > 1 ? $clog2(ALU_LATENCY) : 1;
  typedef enum logic [2:0] {IDLE, GOT_A, GOT_B, EXEC, WAIT_TX} state_t;
  state_t          state;
  logic [TW-1:0]   timer;
  logic [LW-1:0]   lat;
  assign busy = state == EXEC || state == WAIT_TX;
  // timer stops at TIMEOUT_CYCLES-1 (frame is dropped), lat stops at ALU_LATENCY-1, so neither wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      A           <= '0;
      B           <= '0;
      OPCODE      <= '0;
      data_out    <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      timer       <= '0;
      lat         <= '0;
    end else begin
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      if (rx_done_tick && busy) overrun <= 1'b1;
      case (state)
        IDLE: if (rx_done_tick) begin
          A     <= rx_data_in;
          timer <= '0;
          state <= GOT_A;
        end
        GOT_A: if (rx_done_tick) begin
          B     <= rx_data_in;
          timer <= '0;
          state <= GOT_B;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err <= 1'b1;
          state       <= IDLE;
        end else timer <= timer + 1'b1;
        GOT_B: if (rx_done_tick) begin
          OPCODE <= rx_data_in[LEN_OPCODE-1:0];
          lat    <= '0;
          state  <= EXEC;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err <= 1'b1;
          state       <= IDLE;
        end else timer <= timer + 1'b1;
        EXEC: if (lat == LW'(ALU_LATENCY - 1)) begin
          data_out <= alu_data_in;
          tx_start <= 1'b1;
          state    <= WAIT_TX;
        end else lat <= lat + 1'b1;
        WAIT_TX: if (tx_done_tick) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb_uart_alu_sequencer: scoreboard bench; a frame-level model predicts results and timeouts, a monitor checks DUT pulses
module tb_uart_alu_sequencer;
  localparam int L = 3;
  localparam int T = 16;
  logic clk = 0, reset = 0, rx_done_tick = 0, tx_done_tick = 0;
  logic [7:0] rx_data_in = 0, alu_data_in, A, B, data_out;
  logic [5:0] OPCODE;
  logic tx_start, busy, timeout_err, overrun;
  uart_alu_sequencer #(.LEN_DATA(8), .LEN_OPCODE(6), .ALU_LATENCY(L), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data_in(rx_data_in),
    .tx_done_tick(tx_done_tick), .alu_data_in(alu_data_in), .A(A), .B(B), .OPCODE(OPCODE),
    .data_out(data_out), .tx_start(tx_start), .busy(busy), .timeout_err(timeout_err), .overrun(overrun));
  always #5 clk = ~clk;
  assign alu_data_in = A + B + {2'b00, OPCODE};
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  typedef struct {int at; logic [7:0] res;} exp_t;
  exp_t tx_q[$];
  int   to_q[$];
  exp_t mon_e;
  int   mon_t;
  // frame-level reference model
  int m_cnt = 0, m_last = 0, m_op_edge = 0;
  bit m_busy = 0, m_ovr = 0;
  logic [7:0] ma = 0, mb = 0;
  logic [5:0] mop = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (tx_start) begin
      if (tx_q.size() == 0) check("unexpected_tx_start", 1, 0);
      else begin
        mon_e = tx_q.pop_front();
        check("tx_start_cycle", cyc, mon_e.at);
        check("data_out", data_out, mon_e.res);
      end
    end
    if (timeout_err) begin
      if (to_q.size() == 0) check("unexpected_timeout_err", 1, 0);
      else begin
        mon_t = to_q.pop_front();
        check("timeout_cycle", cyc, mon_t);
      end
    end
    if (cyc > 20000) begin
      $display("FAIL watchdog: cycle budget exceeded at %0d", cyc);
      $fatal(1, "watchdog");
    end
  end
  task automatic check_regs();
    check("A", A, ma);
    check("B", B, mb);
    check("OPCODE", OPCODE, mop);
    check("overrun", overrun, m_ovr);
    check("busy", busy, m_busy);
  endtask
  task automatic expire(int q);
    if (!m_busy && m_cnt > 0 && m_last + T <= q) begin
      to_q.push_back(m_last + T);
      m_cnt = 0;
    end
  endtask
  task automatic send(logic [7:0] b, int n);
    int e;
    exp_t x;
    e = cyc + n + 1;
    expire(e - 1);
    if (m_busy) m_ovr = 1;
    else if (m_cnt == 0) begin ma = b; m_cnt = 1; m_last = e; end
    else if (m_cnt == 1) begin mb = b; m_cnt = 2; m_last = e; end
    else begin
      mop = b[5:0];
      m_cnt = 0;
      m_busy = 1;
      m_op_edge = e;
      x.at = e + L;
      x.res = ma + mb + {2'b00, b[5:0]};
      tx_q.push_back(x);
    end
    repeat (n) @(negedge clk);
    rx_data_in = b;
    rx_done_tick = 1;
    @(posedge clk);
    #1 check_regs();
    @(negedge clk);
    rx_done_tick = 0;
  endtask
  task automatic done(int n, bit with_rx, logic [7:0] b);
    if (m_op_edge + L - cyc > n) n = m_op_edge + L - cyc;
    repeat (n) @(negedge clk);
    tx_done_tick = 1;
    if (with_rx) begin
      rx_done_tick = 1;
      rx_data_in = b;
      m_ovr = 1;
    end
    @(posedge clk);
    m_busy = 0;
    #1 check_regs();
    @(negedge clk);
    tx_done_tick = 0;
    rx_done_tick = 0;
  endtask
  task automatic idle(int n);
    expire(cyc + n);
    repeat (n) begin
      @(negedge clk);
      check("busy_idle", busy, m_busy);
    end
  endtask
  task automatic check_zero();
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_OPCODE", OPCODE, 0);
    check("rst_data_out", data_out, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_overrun", overrun, 0);
  endtask
  task automatic do_reset();
    reset = 0;
    #1 check_zero();
    tx_q.delete();
    to_q.delete();
    m_cnt = 0; m_busy = 0; m_ovr = 0; ma = 0; mb = 0; mop = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check_zero();
    reset = 1;
    @(negedge clk);
    // normal frame
    send(8'h05, 0); send(8'h03, 0); send(8'h20, 0);
    done(0, 0, 0);
    // partial frame timeout, then a full frame
    send(8'h11, 0);
    idle(T);
    send(8'hAA, 0); send(8'hBB, 0); send(8'h20, 0);
    done(1, 0, 0);
    // byte on the exact expiry cycle wins
    send(8'h01, 0); send(8'h02, 0); send(8'h03, T - 1);
    done(0, 0, 0);
    // overrun during WAIT_TX and coincident with tx_done
    send(8'h10, 0); send(8'h20, 0); send(8'h30, 0);
    send(8'h77, L + 1);
    done(0, 1, 8'h55);
    send(8'h44, 1); send(8'h22, 2); send(8'h0F, 0);
    done(2, 0, 0);
    // reset while in EXEC
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    do_reset();
    send(8'h09, 0); send(8'h07, 0); send(8'h3F, 0);
    done(0, 0, 0);
    // randomized traffic
    repeat (80) begin
      send(8'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 3)));
      if (m_busy) begin
        if ($urandom_range(0, 3) == 0) send(8'($urandom), int'($urandom_range(0, 4)));
        done(int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0, 8'($urandom));
      end
    end
    idle(T + L + 2);
    check("tx_queue_drained", tx_q.size(), 0);
    check("timeout_queue_drained", to_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_alu_sequencer.md
# uart_alu_sequencer

Frame sequencer between the UART receiver/transmitter and the ALU of the UART-ALU design. It collects a three-byte command frame (A, B, OPCODE) from the receiver. It waits a fixed ALU settling time, then hands the result to the transmitter and holds off new frames until transmission completes. It adds an inter-byte timeout and overrun detection, so a lost byte cannot desynchronise the frame counter.

## Interface
- LEN_DATA, 8, width of UART bytes, A, B and ALU result
- LEN_OPCODE, 6, width of OPCODE (low bits of third byte)
- ALU_LATENCY, 1, clock cycles (≥1) between OPCODE register update and result capture
- TIMEOUT_CYCLES, 1000000, max clock cycles allowed between bytes of one frame (≥2)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- rx_done_tick  in  1  one-cycle pulse, rx_data_in valid
- rx_data_in  in  LEN_DATA  received byte
- tx_done_tick  in  1  one-cycle pulse, transmitter finished byte
- alu_data_in  in  LEN_DATA  combinational ALU result of A, B, OPCODE
- A  out  LEN_DATA  operand A register
- B  out  LEN_DATA  operand B register
- OPCODE  out  LEN_OPCODE  opcode register
- data_out  out  LEN_DATA  captured result to transmitter
- tx_start  out  1  one-cycle pulse, data_out valid
- busy  out  1  high in EXEC and WAIT_TX
- timeout_err  out  1  one-cycle pulse, partial frame discarded
- overrun  out  1  sticky, byte received while busy

## Operation
- States: IDLE, GOT_A, GOT_B, EXEC, WAIT_TX.
- IDLE: rx_done_tick → A <= rx_data_in, clear timer, go GOT_A.
- GOT_A: rx_done_tick → B <= rx_data_in, clear timer, go GOT_B.
- GOT_B: rx_done_tick → OPCODE <= rx_data_in[LEN_OPCODE-1:0], clear latency counter, go EXEC.
- Timeout in GOT_A/GOT_B: timer increments every cycle without rx_done_tick.
  - When timer reaches TIMEOUT_CYCLES-1 with no tick: pulse timeout_err, go IDLE.
  - A/B keep their values; they are not cleared.
  - Same-cycle tick and expiry: tick wins, no error.
- EXEC: latency counter counts ALU_LATENCY cycles. On the final cycle:
  - data_out <= alu_data_in;
  - tx_start <= 1 for exactly one cycle;
  - go WAIT_TX.
- WAIT_TX: tx_done_tick → go IDLE. tx_done_tick in any other state is ignored.
- rx_done_tick in EXEC or WAIT_TX: byte dropped, overrun <= 1. overrun is cleared only by reset.
- busy is a combinational decode of the state register. The ALU sees A/B/OPCODE continuously; registers change only on accepted bytes.

## Timing
- Reset (reset=0, immediate, asynchronous):
  - state IDLE;
  - A, B, OPCODE, data_out = 0;
  - tx_start, busy, timeout_err, overrun = 0.
- Reset mid-frame or mid-transmit aborts; a pending tx_start is dropped.
- Byte capture latency: register updates on the edge that samples rx_done_tick.
- OPCODE tick sampled at edge k:
  - EXEC for ALU_LATENCY cycles;
  - data_out loads and tx_start rises at edge k+ALU_LATENCY;
  - tx_start falls at edge k+ALU_LATENCY+1.
- Back-to-back: a new A byte is accepted in IDLE on the cycle after the edge that sampled tx_done_tick. A tick coincident with tx_done_tick in WAIT_TX counts as overrun.
- Timer and latency counters: $clog2-sized, saturate, never wrap.
- timeout_err rises exactly TIMEOUT_CYCLES cycles after the last accepted byte edge.

## Test plan
- Normal frame, ALU_LATENCY=1, alu_data_in = A+B stub: bytes 0x05, 0x03, 0x20 → A=0x05, B=0x03, OPCODE=0x20, data_out=0x08, single tx_start pulse one cycle after OPCODE load; tx_done_tick → busy=0.
- ALU_LATENCY=3: same frame → tx_start rises exactly 3 edges after OPCODE tick; busy high from then until tx_done_tick.
- TIMEOUT_CYCLES=16: send 0x11 only, idle 16 cycles → timeout_err one pulse, state IDLE; then 0xAA, 0xBB, 0x20 → A=0xAA, B=0xBB, correct result sent.
- Tick on the exact expiry cycle in GOT_B → accepted as OPCODE, no timeout_err.
- Extra byte 0x77 during WAIT_TX → overrun=1 and stays 1, A unchanged; next frame processes normally.
- Assert reset low during EXEC → all outputs 0 immediately, no tx_start; frame after release processes normally.
